// File: rtl/sysarr_result_drain_if.sv
// rtl/sysarr_result_drain_if.sv - result stream bundle between the drain and the writeback side
//
// Purpose: groups the row-major result stream of sysarr_result_drain.
// Signals:
//   res_data   word C[row][col]          (master -> slave)
//   res_row    row index of res_data     (master -> slave)
//   res_col    column index of res_data  (master -> slave)
//   res_valid  beat valid                (master -> slave)
//   res_last   high with C[n-1][n-1]     (master -> slave)
//   res_err    fp exception flag for op  (master -> slave)
//   res_ready  beat accepted             (slave -> master)
interface sysarr_result_drain_if #(
  parameter int N = 31,
  parameter int n = 4
);
  logic [N:0]           res_data;
  logic [$clog2(n)-1:0] res_row;
  logic [$clog2(n)-1:0] res_col;
  logic                 res_valid;
  logic                 res_last;
  logic                 res_err;
  logic                 res_ready;

  modport master (
    output res_data, res_row, res_col, res_valid, res_last, res_err,
    input  res_ready
  );

  modport slave (
    input  res_data, res_row, res_col, res_valid, res_last, res_err,
    output res_ready
  );
endinterface

// File: rtl/sysarr_result_drain.sv
// rtl/sysarr_result_drain.sv - captures the n x n systolic-array result and streams it out row-major
//
// Purpose: owns the step counter flg for one matrix op, captures the n result rows
// from outrow into a buffer, then drains n*n words over a valid/ready stream.
// Optional feature: define SYSARR_DRAIN_EXC_EN to flag Inf/NaN words on res_err.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   pulse: begin one op (accepted only in IDLE)
//   outrow  one result row, word j at [(N+1)*j +: N+1]
//   flg     step counter driven to the array
//   busy    high outside IDLE
//   ovr     sticky: start seen while busy
//   res     result stream (master modport of sysarr_result_drain_if)
module sysarr_result_drain #(
  parameter int N   = 31,
  parameter int n   = 4,
  parameter int LAT = 2 * n - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(N+1)*n-1:0]     outrow,
  output logic [6:0]             flg,
  output logic                   busy,
  output logic                   ovr,
  sysarr_result_drain_if.master  res
);

  localparam int RW = $clog2(n);
  localparam logic [6:0] FLG_LAT = 7'(LAT);
  localparam logic [RW-1:0] IDX_LAST = RW'(n - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // flg is 7 bits; the whole op must fit before it would wrap.
  if ((LAT + n) >= 128) begin : g_lat_check
    $error("sysarr_result_drain: LAT+n must be < 128");
  end

  logic [1:0]         r_state;
  logic [6:0]         r_flg;
  logic               r_ovr;
  logic               r_valid;
  logic [RW-1:0]      r_row;
  logic [RW-1:0]      r_col;
  logic [(N+1)*n-1:0] r_buf [n];

  logic [RW-1:0]      w_cap_row;
  logic               w_xfer;
  logic               w_last;
  logic [N:0]         w_word;

  // Row being captured is the step offset past the array latency.
  assign w_cap_row = RW'(r_flg - FLG_LAT);
  assign w_xfer    = r_valid & res.res_ready;
  assign w_last    = r_valid && (r_row == IDX_LAST) && (r_col == IDX_LAST);
  assign w_word    = r_buf[r_row][int'(r_col) * (N+1) +: N+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_flg   <= '0;
      r_ovr   <= 1'b0;
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      if (start && (r_state != S_IDLE)) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_flg   <= '0;
            r_state <= (LAT == 0) ? S_CAP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_flg <= r_flg + 7'd1;
          if ((r_flg + 7'd1) == FLG_LAT) r_state <= S_CAP;
        end
        S_CAP: begin
          r_flg <= r_flg + 7'd1;
          if (w_cap_row == IDX_LAST) begin
            // Beat (0,0) is presented as soon as the last row lands; flg then holds at LAT+n.
            r_state <= S_DRAIN;
            r_valid <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_flg   <= '0;
              r_row   <= '0;
              r_col   <= '0;
            end else if (r_col == IDX_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result storage is deliberately not reset; every row is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (r_state == S_CAP) r_buf[w_cap_row] <= outrow;
  end

`ifdef SYSARR_DRAIN_EXC_EN
  logic r_exc;
  logic w_row_exc;

  // fp32 exponent field of each word is its bits [N-1 -: 8].
  always_comb begin
    w_row_exc = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (outrow[(N+1)*j + N-1 -: 8] == 8'hFF) w_row_exc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_exc <= 1'b0;
    end else if ((r_state == S_CAP) && w_row_exc) begin
      r_exc <= 1'b1;
    end
  end

  assign res.res_err = r_valid & r_exc;
`else
  assign res.res_err = 1'b0;
`endif

  assign flg           = r_flg;
  assign busy          = (r_state != S_IDLE);
  assign ovr           = r_ovr;
  assign res.res_data  = r_valid ? w_word : '0;
  assign res.res_row   = r_row;
  assign res.res_col   = r_col;
  assign res.res_valid = r_valid;
  assign res.res_last  = w_last;

endmodule

// File: tb/tb_sysarr_result_drain.sv
// tb/tb_sysarr_result_drain.sv - scoreboard bench for sysarr_result_drain
module tb_sysarr_result_drain;

  localparam int N   = 31;
  localparam int n   = 4;
  localparam int LAT = 7;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        last;
    logic        err;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [127:0]   outrow = '0;
  logic [6:0]     flg;
  logic           busy;
  logic           ovr;

  sysarr_result_drain_if #(.N(N), .n(n)) res_if ();

  sysarr_result_drain #(.N(N), .n(n), .LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .outrow (outrow),
    .flg    (flg),
    .busy   (busy),
    .ovr    (ovr),
    .res    (res_if.master)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    xfers   = 0;
  bit    last_seen = 0;
  beat_t q[$];
  logic [31:0] mat [4][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected beat per transfer and checks hold-stability during stalls.
  bit          prev_stall = 0;
  logic [31:0] h_d;
  logic [1:0]  h_r, h_c;
  logic        h_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && res_if.res_valid) begin
        chk("stall_data", res_if.res_data, h_d);
        chk("stall_row", 32'(res_if.res_row), 32'(h_r));
        chk("stall_col", 32'(res_if.res_col), 32'(h_c));
        chk("stall_last", 32'(res_if.res_last), 32'(h_l));
      end
      if (res_if.res_valid && res_if.res_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got row %0d col %0d expected no beat", res_if.res_row, res_if.res_col);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", res_if.res_data, e.d);
          chk("beat_row", 32'(res_if.res_row), 32'(e.r));
          chk("beat_col", 32'(res_if.res_col), 32'(e.c));
          chk("beat_last", 32'(res_if.res_last), 32'(e.last));
          chk("beat_err", 32'(res_if.res_err), 32'(e.err));
          chk("beat_flg", 32'(flg), 32'(LAT + n));
        end
        xfers++;
        if (res_if.res_last) last_seen = 1;
        prev_stall = 0;
      end else if (res_if.res_valid) begin
        prev_stall = 1;
        h_d = res_if.res_data;
        h_r = res_if.res_row;
        h_c = res_if.res_col;
        h_l = res_if.res_last;
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic fill(input int op, input bit exc);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mat[r][c] = 32'h3EC00000 + (op << 12) + (r << 4) + c;
    if (exc) mat[2][1] = 32'h7F800000;
  endtask

  // One op: ready_mode 0 = always ready, 1 = pattern 1,0,0,1; abort_at>0 resets while that beat is shown.
  task automatic run_op(input int op, input bit exc, input int ready_mode, input bit poke, input int abort_at);
    bit done = 0;
    bit exp_err = 0;
    fill(op, exc);
`ifdef SYSARR_DRAIN_EXC_EN
    exp_err = exc;
`endif
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        q.push_back({mat[r][c], 2'(r), 2'(c), (r == 3 && c == 3), exp_err});
    xfers = 0;
    last_seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (last_seen) begin
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("flg_after_last", 32'(flg), 32'd0);
        chk("valid_after_last", 32'(res_if.res_valid), 32'd0);
        last_seen = 0;
        done = 1;
        break;
      end
      if (abort_at > 0 && xfers == abort_at - 1 && res_if.res_valid) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(res_if.res_valid), 32'd0);
        chk("rst_flg", 32'(flg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(res_if.res_last), 32'd0);
        q.delete();
        #1 rst_n = 1'b1;
        done = 1;
        break;
      end
      if (flg >= 7'(LAT) && flg < 7'(LAT + n))
        for (int c = 0; c < 4; c++) outrow[32*c +: 32] = mat[flg - 7'(LAT)][c];
      else
        outrow = {4{32'hDEADBEEF}};
      res_if.res_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      start = poke && (flg == 7'(LAT + 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_if.res_ready = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL op_timeout: got busy %0d expected op to finish", busy);
    end
    if (abort_at == 0) begin
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("beat_count", 32'(xfers), 32'd16);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    res_if.res_ready = 1'b0;
    #1;
    chk("rst0_flg", 32'(flg), 32'd0);
    chk("rst0_busy", 32'(busy), 32'd0);
    chk("rst0_ovr", 32'(ovr), 32'd0);
    chk("rst0_valid", 32'(res_if.res_valid), 32'd0);
    chk("rst0_last", 32'(res_if.res_last), 32'd0);
    chk("rst0_err", 32'(res_if.res_err), 32'd0);
    chk("rst0_row", 32'(res_if.res_row), 32'd0);
    chk("rst0_col", 32'(res_if.res_col), 32'd0);
    chk("rst0_data", res_if.res_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 0, 0, 0);
    chk("ovr_clean", 32'(ovr), 32'd0);
    run_op(1, 0, 1, 0, 0);
    run_op(2, 0, 0, 1, 0);
    chk("ovr_set", 32'(ovr), 32'd1);
    run_op(3, 1, 0, 0, 0);
    chk("ovr_sticky", 32'(ovr), 32'd1);
    run_op(4, 0, 1, 0, 0);
    run_op(5, 0, 0, 0, 5);
    chk("ovr_after_rst", 32'(ovr), 32'd0);
    run_op(6, 0, 1, 0, 0);
    chk("busy_idle_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
